// File: rtl/hamming_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hamming_stream_encoder: 2-stage valid/ready systematic Hamming       |
// | encoder. Macro HAMMING_SECDED_EN adds an overall parity MSB (SECDED). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hamming_stream_encoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = (DATA_W <= 1)  ? 2 :
                          (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = DATA_W + PAR_W + 1
`else
  localparam int CODE_W = DATA_W + PAR_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  word_cnt
);

  // Data bits covered by parity bit j: data index i sits at the i-th
  // non-power-of-two codeword position.
  function automatic logic [DATA_W-1:0] par_mask(input int j);
    logic [DATA_W-1:0] m;
    int                d;
    m = '0;
    d = 0;
    for (int pos = 1; pos <= DATA_W + PAR_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if ((((pos >> j) & 1) != 0) && (d < DATA_W)) begin
          m = m | (DATA_W'(1) << d);
        end
        d++;
      end
    end
    return m;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CODE_W-1:0] s2_code_q,  s2_code_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic              s2_load;
  logic              in_xfer;
  logic              out_xfer;
  logic [PAR_W-1:0]  parity;
  logic [CODE_W-1:0] code;

  for (genvar j = 0; j < PAR_W; j++) begin : g_par
    localparam logic [DATA_W-1:0] MASK = par_mask(j);
    assign parity[j] = ^(s1_data_q & MASK);
  end

`ifdef HAMMING_SECDED_EN
  assign code = {^{s1_data_q, parity}, s1_data_q, parity};
`else
  assign code = {s1_data_q, parity};
`endif

  assign s2_load   = !s2_valid_q || out_ready;
  assign in_ready  = !clear && (!s1_valid_q || s2_load);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = s2_valid_q && out_ready;
  assign out_valid = s2_valid_q;
  assign out_code  = s2_code_q;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    word_cnt_d = word_cnt_q;
    if (clear) begin
      // A transfer at the sink this cycle still happens, but is not counted.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      word_cnt_d = '0;
    end else begin
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_code_d = code;
        end
      end
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_xfer) begin
          s1_data_d = in_data;
        end
      end
      if (out_xfer) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hamming_stream_encoder: directed bench for DATA_W=4/CNT_W=4 and   |
// | DATA_W=8/CNT_W=16 instances. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int CW4 = 8;
  localparam int CW8 = 13;
  localparam logic [63:0] EXP4_1 = 64'h8B;
`else
  localparam int CW4 = 7;
  localparam int CW8 = 12;
  localparam logic [63:0] EXP4_1 = 64'h0B;
`endif
  localparam logic [63:0] EXP4_B  = 64'h59;
  localparam logic [63:0] EXP8_FF = 64'hFF3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear, in_valid, out_ready, in_ready, out_valid;
  logic [3:0]     in_data;
  logic [CW4-1:0] out_code;
  logic [3:0]     word_cnt;

  logic           clear8, in_valid8, out_ready8, in_ready8, out_valid8;
  logic [7:0]     in_data8;
  logic [CW8-1:0] out_code8;
  logic [15:0]    word_cnt8;

  int errors = 0;
  int checks = 0;

  hamming_stream_encoder #(.DATA_W(4), .CNT_W(4)) u_enc4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .word_cnt(word_cnt)
  );

  hamming_stream_encoder #(.DATA_W(8), .CNT_W(16)) u_enc8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_code(out_code8),
    .word_cnt(word_cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: place bits by position, then XOR per parity group.
  function automatic logic [63:0] ref_code(input int dw, input logic [63:0] d);
    int           pw;
    int           di;
    logic [127:0] cw;
    logic [63:0]  par;
    logic [63:0]  r;
    pw = 1;
    while ((1 << pw) < dw + pw + 1) pw++;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= dw + pw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    par = '0;
    for (int j = 0; j < pw; j++)
      for (int pos = 1; pos <= dw + pw; pos++)
        if (((pos >> j) & 1) == 1) par[j] = par[j] ^ cw[pos];
    r = (d << pw) | par;
`ifdef HAMMING_SECDED_EN
    r[dw + pw] = ^r;
`endif
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sb[$];
    logic [3:0] stream [4];
    int         sent, rcvd, idx, stale;
    logic       rdy_ok;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    clear8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // T1: hand vectors through the 4-bit instance, latency 2
    in_valid = 1'b1; in_data = 4'hB; out_ready = 1'b1;
    tick();
    in_data = 4'h1;
    check("t1_lat_not_yet", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t1_valid_b", out_valid, 1);
    check("t1_code_b", out_code, EXP4_B);
    tick();
    check("t1_code_1", out_code, EXP4_1);
    tick();
    check("t1_drained", out_valid, 0);
    check("t1_cnt", word_cnt, 2);

    // T3: 8-bit directed then random stream against the reference model
    in_valid8 = 1'b1; in_data8 = 8'hFF; out_ready8 = 1'b1;
    tick();
    in_data8 = 8'h00;
    tick();
    in_valid8 = 1'b0;
    check("t3_code_ff", out_code8, EXP8_FF);
    tick();
    check("t3_code_00", out_code8, 0);
    check("t3_valid_00", out_valid8, 1);
    tick();
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 6000 && rcvd < 1000; cyc++) begin
      in_valid8  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data8   = 8'($urandom);
      out_ready8 = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid8 && in_ready8) begin
        sb.push_back(in_data8);
        sent++;
      end
      if (out_valid8 && out_ready8) begin
        if (sb.size() == 0) check("t3_extra_word", 1, 0);
        else check("t3_rand", out_code8, ref_code(8, {56'd0, sb.pop_front()}));
        rcvd++;
      end
      tick();
    end
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    check("t3_rand_count", rcvd, 1000);
    check("t3_cnt", word_cnt8, 1002);

    // T4: stall holds exactly two words, then drains in order
    stream[0] = 4'hB; stream[1] = 4'h1; stream[2] = 4'h5; stream[3] = 4'h7;
    idx = 0; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = stream[(idx > 3) ? 3 : idx];
      #1;
      if (in_ready) idx++;
      tick();
    end
    check("t4_accepted", idx, 2);
    check("t4_in_ready", in_ready, 0);
    check("t4_valid", out_valid, 1);
    check("t4_code_held", out_code, EXP4_B);
    tick();
    tick();
    check("t4_code_still", out_code, EXP4_B);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("t4_second_valid", out_valid, 1);
    check("t4_second", out_code, EXP4_1);
    tick();
    check("t4_empty", out_valid, 0);
    check("t4_cnt", word_cnt, 4);

    clear = 1'b1;
    #1;
    check("clr_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    check("clr_cnt", word_cnt, 0);

    // T5: 20 back-to-back words, CNT_W=4 wraps to 4
    rdy_ok = 1'b1;
    for (int k = 0; k < 22; k++) begin
      in_valid = (k < 20);
      in_data  = 4'(k);
      #1;
      if (!in_ready) rdy_ok = 1'b0;
      check("t5_valid", out_valid, ((k >= 2) && (k <= 21)) ? 1 : 0);
      if (k >= 2) check("t5_code", out_code, ref_code(4, 64'((k - 2) % 16)));
      tick();
    end
    in_valid = 1'b0;
    check("t5_in_ready_high", rdy_ok, 1);
    check("t5_cnt_wrap", word_cnt, 4);

    // T6a: clear with two words in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hB;
    tick();
    in_data = 4'h1;
    tick();
    in_valid = 1'b0;
    check("t6_full", out_valid, 1);
    clear = 1'b1; out_ready = 1'b1;
    #1;
    check("t6_clr_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    check("t6_clr_valid", out_valid, 0);
    check("t6_clr_cnt", word_cnt, 0);
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) stale++;
    end
    check("t6_clr_stale", stale, 0);

    // T6b: asynchronous reset with two words in flight
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hB;
    tick();
    in_data = 4'h1;
    tick();
    out_ready = 1'b1; in_data = 4'h5;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("t6_pre_rst_cnt", word_cnt, 1);
    check("t6_pre_rst_code", out_code, EXP4_1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_cnt", word_cnt, 0);
    check("t6_rst_code", out_code, 0);
    check("t6_rst_in_ready", in_ready, 1);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) stale++;
    end
    check("t6_rst_stale", stale, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
